adc_trigger_capture: RTL and testbench
======================================

# adc_trigger_capture

Parametrised serial-ADC front end for the oscilloscope datapath. It generates the ADC conversion clock and strobe, deserialises each frame, and extracts the sample field. A trigger state machine (auto, rising-edge or falling-edge threshold; single-shot or continuous) then forwards exactly `capture_len` samples per capture into the write side of the sample FIFO. It supersedes the fixed 16-bit, free-running ADC reader, and sits between the ADC pins and the FIFO write port.

## Interface
- `CLK_DIV_LOG2`, default 6: `adc_clk` half-period is 2^`CLK_DIV_LOG2` `osc_clk` cycles.
- `FRAME_BITS`, default 16: serial bits per conversion frame, MSB first.
- `MSB_PAD`, default 2: leading pad bits discarded before the sample field.
- `DATA_W`, default 8: sample width.
- `CONV_CYCLES`, default 3: `adc_clk` periods with `adc_conv` high between frames.
- `LEN_W`, default 16: width of `capture_len`.
- `osc_clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `adc_data` in 1: serial data from the ADC.
- `adc_clk` out 1: divided conversion clock, registered.
- `adc_conv` out 1: conversion strobe, registered.
- `start` in 1: one-cycle pulse that arms a capture.
- `abort` in 1: one-cycle pulse that returns the block to IDLE.
- `trig_mode` in 2: 0 = auto, 1 = rising, 2 = falling, 3 = reserved (treated as auto).
- `continuous` in 1: re-arm automatically after each capture.
- `trig_level` in `DATA_W`: unsigned threshold.
- `capture_len` in `LEN_W`: samples per capture; 0 is treated as 1.
- `sink_full` in 1: FIFO full flag.
- `wr_en` out 1: one-cycle write strobe.
- `wr_data` out `DATA_W`: sample to write.
- `armed` out 1: high in ARMED.
- `busy` out 1: high in ARMED or CAPTURE.
- `done` out 1: one-cycle pulse at the end of each capture.
- `overrun` out 1: sticky; cleared by `start` or `reset`.

## Operation
- Divider: free-running counter of `CLK_DIV_LOG2`+1 bits, and `adc_clk` is its MSB. The cycle in which `adc_clk` goes 0→1 is the internal `tick`.
- Frame sequencer: counter 0..`CONV_CYCLES`+`FRAME_BITS`-1 that advances on each `tick` and wraps.
  - `adc_conv` is 1 for counts 0..`CONV_CYCLES`-1 and 0 otherwise.
  - During each low-conv count, `adc_data` is shifted in at that `tick`.
- Sample extraction: after the last bit, `sample = frame[FRAME_BITS-1-MSB_PAD -: DATA_W]`. A one-cycle `sample_vld` is raised on the next `osc_clk`, and the sample is also stored as `prev`.
- Trigger FSM states: IDLE, ARMED, CAPTURE.
  - IDLE → ARMED on `start`. This also clears `overrun` and invalidates `prev`.
  - ARMED → CAPTURE on `sample_vld` when the trigger holds. The triggering sample is the first sample written.
    - Auto: every sample triggers.
    - Rising: requires `prev` valid, `prev < trig_level` and `sample >= trig_level`.
    - Falling: requires `prev` valid, `prev > trig_level` and `sample <= trig_level`.
  - In CAPTURE, each `sample_vld` counts one sample. If `!sink_full`, pulse `wr_en` with `wr_data` = sample. If `sink_full`, drop the sample, set `overrun`, and still count it.
  - After `capture_len` counted samples, pulse `done`. Go to ARMED if `continuous`, otherwise IDLE.
  - `abort` in any state: go to IDLE with no `done`. `abort` wins over `start` when both are asserted in the same cycle.
  - `start` is ignored outside IDLE.
- `trig_mode`, `trig_level`, `capture_len` and `continuous` are latched on `start`.

## Timing
- Reset values: `adc_clk` 0, `adc_conv` 1, `wr_en` 0, `wr_data` 0, `armed` 0, `busy` 0, `done` 0, `overrun` 0. FSM in IDLE, sequencer count 0, divider 0, `prev` invalid.
- Divider and sequencer run in every FSM state, so ADC timing is unaffected by the trigger logic.
- Latency: `wr_en` asserts 2 `osc_clk` cycles after the `tick` that samples the last frame bit. The path is shift, then `sample_vld`, then the registered write.
- `done` coincides with the `wr_en` cycle of the last sample, or with its drop cycle.
- Sample rate = `osc_clk` / (2^(`CLK_DIV_LOG2`+1) · (`CONV_CYCLES`+`FRAME_BITS`)).
- `sink_full` is sampled in the same cycle as `sample_vld`.
- In continuous mode, the re-armed FSM keeps `prev` set to the last captured sample, so an edge can trigger on the very next sample.

## Structure
- Shared package `oscope_pkg`:
  - `trig_mode_t` enum: AUTO, RISE, FALL.
  - `cap_state_t` enum: IDLE, ARMED, CAPTURE.
  - Default `DATA_W` and `FRAME_BITS` constants.
- One sub-module, `adc_serial_rx`, containing the divider, the frame sequencer and the shift register. Its outputs are `adc_clk`, `adc_conv`, `sample`, and `sample_vld`.
- The trigger FSM, capture counter and sink interface stay in the top module.

## Test plan
- Reset and frame: `CLK_DIV_LOG2`=1. Drive frame 0x6D4F MSB first on `adc_conv` low → sample 0xB5 (181). Auto, `capture_len`=1: exactly one `wr_en` with 0xB5, a `done` pulse, then IDLE.
- Rising trigger, `trig_level`=0x80: sample stream 0x10, 0x70, 0x90, 0xA0, 0x20 with `capture_len`=2 → writes 0x90, 0xA0; no write for 0x10 or 0x70.
- Falling trigger, `trig_level`=0x80, `continuous`=1, `capture_len`=1: stream 0x90, 0x80, 0xA0, 0x70 → writes 0x80 and 0x70, two `done` pulses, `busy` stays 1.
- Overrun: auto, `capture_len`=4, `sink_full` high on the 2nd sample → 3 writes, `overrun`=1, `done` after the 4th sample. A following `start` clears `overrun`.
- Abort and reset: `abort` mid-CAPTURE → IDLE, no `done`, no further writes. `reset` mid-frame → all outputs return to their reset values asynchronously, and the next frame starts with `adc_conv` high for `CONV_CYCLES` periods.
- Parameter sweep: `FRAME_BITS`=12, `MSB_PAD`=0, `DATA_W`=12, frame 0xABC → `wr_data` 0xABC.

Source files
------------

// File: rtl/oscope_pkg.sv
// rtl/oscope_pkg.sv - shared types and defaults for the oscilloscope datapath
package oscope_pkg;

  typedef enum logic [1:0] {
    AUTO = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } trig_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FRAME_BITS = 16;

  // Encoding 3 is reserved and behaves like auto.
  function automatic trig_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return RISE;
      2'd2:    return FALL;
      default: return AUTO;
    endcase
  endfunction

endpackage

// File: rtl/adc_serial_rx.sv
// rtl/adc_serial_rx.sv - ADC clock/strobe generation, frame deserialiser and sample extraction
module adc_serial_rx
  import oscope_pkg::*;
#(
  parameter int CLK_DIV_LOG2 = 6,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int MSB_PAD      = 2,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CONV_CYCLES  = 3
) (
  input  logic              osc_clk,
  input  logic              reset,
  input  logic              adc_data,
  output logic              adc_clk,
  output logic              adc_conv,
  output logic [DATA_W-1:0] sample,
  output logic              sample_vld
);

  localparam int SEQ_LEN = CONV_CYCLES + FRAME_BITS;
  localparam int SEQ_W   = $clog2(SEQ_LEN);
  localparam logic [CLK_DIV_LOG2:0] TICK_VAL = (CLK_DIV_LOG2 + 1)'((1 << CLK_DIV_LOG2) - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_LEN - 1);
  localparam logic [SEQ_W-1:0] CONV_CNT = SEQ_W'(CONV_CYCLES);

  logic [CLK_DIV_LOG2:0] div_cnt;
  logic [SEQ_W-1:0]      seq_cnt;
  logic [SEQ_W-1:0]      seq_nxt;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  last_bit_q;
  logic                  tick;

  // tick is the cycle whose edge takes adc_clk from 0 to 1
  assign adc_clk = div_cnt[CLK_DIV_LOG2];
  assign tick    = (div_cnt == TICK_VAL);
  assign seq_nxt = (seq_cnt == SEQ_LAST) ? '0 : seq_cnt + 1'b1;

  // Free-running divider, independent of the trigger logic
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame sequencer: conv strobe for the first counts, then shift one data bit per tick
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      seq_cnt    <= '0;
      adc_conv   <= 1'b1;
      shift_q    <= '0;
      last_bit_q <= 1'b0;
    end else begin
      last_bit_q <= 1'b0;
      if (tick) begin
        seq_cnt    <= seq_nxt;
        adc_conv   <= (seq_nxt < CONV_CNT);
        last_bit_q <= (seq_cnt == SEQ_LAST);
        if (seq_cnt >= CONV_CNT) begin
          shift_q <= {shift_q[FRAME_BITS-2:0], adc_data};
        end
      end
    end
  end

  // Extract the sample field one cycle after the last bit lands
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      sample     <= '0;
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= last_bit_q;
      if (last_bit_q) begin
        sample <= shift_q[FRAME_BITS-1-MSB_PAD -: DATA_W];
      end
    end
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// rtl/adc_trigger_capture.sv - serial ADC front end with threshold trigger and fixed-length capture
module adc_trigger_capture
  import oscope_pkg::*;
#(
  parameter int CLK_DIV_LOG2 = 6,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int MSB_PAD      = 2,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CONV_CYCLES  = 3,
  parameter int LEN_W        = 16
) (
  input  logic              osc_clk,
  input  logic              reset,
  input  logic              adc_data,
  output logic              adc_clk,
  output logic              adc_conv,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic              continuous,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [LEN_W-1:0]  capture_len,
  input  logic              sink_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              armed,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  logic [DATA_W-1:0] sample;
  logic              sample_vld;

  cap_state_t        state, state_nxt;
  trig_mode_t        mode_q;
  logic [DATA_W-1:0] level_q;
  logic [LEN_W-1:0]  len_q;
  logic              cont_q;
  logic [DATA_W-1:0] prev_q;
  logic              prev_vld;
  logic [LEN_W-1:0]  cnt_q;
  logic              trig_hit;
  logic              accept;
  logic              last;
  logic              arm_now;

  adc_serial_rx #(
    .CLK_DIV_LOG2(CLK_DIV_LOG2),
    .FRAME_BITS  (FRAME_BITS),
    .MSB_PAD     (MSB_PAD),
    .DATA_W      (DATA_W),
    .CONV_CYCLES (CONV_CYCLES)
  ) u_rx (
    .osc_clk   (osc_clk),
    .reset     (reset),
    .adc_data  (adc_data),
    .adc_clk   (adc_clk),
    .adc_conv  (adc_conv),
    .sample    (sample),
    .sample_vld(sample_vld)
  );

  assign arm_now = (state == IDLE) && start && !abort;
  assign armed   = (state == ARMED);
  assign busy    = (state != IDLE);

  // Trigger decision, sample acceptance and next state; abort overrides everything
  always_comb begin
    trig_hit  = 1'b1;
    accept    = 1'b0;
    last      = 1'b0;
    state_nxt = state;
    case (mode_q)
      RISE:    trig_hit = prev_vld && (prev_q < level_q) && (sample >= level_q);
      FALL:    trig_hit = prev_vld && (prev_q > level_q) && (sample <= level_q);
      default: trig_hit = 1'b1;
    endcase
    accept = !abort && sample_vld &&
             ((state == CAPTURE) || ((state == ARMED) && trig_hit));
    last   = accept && ((cnt_q + 1'b1) == len_q);
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:          if (start) state_nxt = ARMED;
        ARMED, CAPTURE: begin
          if (last)        state_nxt = cont_q ? ARMED : IDLE;
          else if (accept) state_nxt = CAPTURE;
        end
        default:       state_nxt = IDLE;
      endcase
    end
  end

  // Capture settings are frozen when a capture is armed
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      mode_q  <= AUTO;
      level_q <= '0;
      len_q   <= LEN_W'(1);
      cont_q  <= 1'b0;
    end else if (arm_now) begin
      mode_q  <= decode_mode(trig_mode);
      level_q <= trig_level;
      len_q   <= (capture_len == '0) ? LEN_W'(1) : capture_len;
      cont_q  <= continuous;
    end
  end

  // State, sample counter, previous-sample tracker and registered sink outputs
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt_q    <= '0;
      prev_q   <= '0;
      prev_vld <= 1'b0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_en <= accept && !sink_full;
      done  <= last;
      if (accept && !sink_full) wr_data <= sample;
      if (state_nxt != CAPTURE) cnt_q <= '0;
      else if (accept)          cnt_q <= cnt_q + 1'b1;
      if (arm_now)                  overrun <= 1'b0;
      else if (accept && sink_full) overrun <= 1'b1;
      if (arm_now) begin
        prev_vld <= 1'b0;
      end else if (sample_vld) begin
        prev_q   <= sample;
        prev_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// tb/tb_adc_trigger_capture.sv - directed scoreboard bench for adc_trigger_capture
module tb_adc_trigger_capture;

  logic        osc_clk = 1'b0;
  logic        reset;
  always #5 osc_clk = ~osc_clk;

  logic        adc_data, adc_clk, adc_conv, start, abort, continuous, sink_full;
  logic [1:0]  trig_mode;
  logic [7:0]  trig_level, wr_data;
  logic [15:0] capture_len;
  logic        wr_en, armed, busy, done, overrun;

  logic        adc_data_b, adc_clk_b, adc_conv_b, start_b, wr_en_b;
  logic        armed_b, busy_b, done_b, overrun_b;
  logic [11:0] wr_data_b;

  adc_trigger_capture #(.CLK_DIV_LOG2(1)) dut (
    .osc_clk(osc_clk), .reset(reset), .adc_data(adc_data), .adc_clk(adc_clk),
    .adc_conv(adc_conv), .start(start), .abort(abort), .trig_mode(trig_mode),
    .continuous(continuous), .trig_level(trig_level), .capture_len(capture_len),
    .sink_full(sink_full), .wr_en(wr_en), .wr_data(wr_data), .armed(armed),
    .busy(busy), .done(done), .overrun(overrun)
  );

  adc_trigger_capture #(.CLK_DIV_LOG2(1), .FRAME_BITS(12), .MSB_PAD(0), .DATA_W(12)) dut_b (
    .osc_clk(osc_clk), .reset(reset), .adc_data(adc_data_b), .adc_clk(adc_clk_b),
    .adc_conv(adc_conv_b), .start(start_b), .abort(1'b0), .trig_mode(2'd0),
    .continuous(1'b0), .trig_level(12'h000), .capture_len(16'd1),
    .sink_full(1'b0), .wr_en(wr_en_b), .wr_data(wr_data_b), .armed(armed_b),
    .busy(busy_b), .done(done_b), .overrun(overrun_b)
  );

  int checks = 0, passes = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [7:0] v);
    return {2'b00, v, 6'b000000};
  endfunction

  // ADC model: presents the next frame bit on each falling adc_clk while conv is low
  logic [15:0] fq[$];
  logic [15:0] stage[$];
  logic [15:0] cur;
  int          bitn = 0;
  always @(negedge adc_clk) begin
    if (adc_conv) bitn = 0;
    else if (bitn < 16) begin
      if (bitn == 0) cur = (fq.size() > 0) ? fq.pop_front() : mk(8'h55);
      adc_data = cur[15 - bitn];
      bitn++;
    end
  end

  logic [11:0] fq_b[$];
  logic [11:0] cur_b;
  int          bitn_b = 0;
  always @(negedge adc_clk_b) begin
    if (adc_conv_b) bitn_b = 0;
    else if (bitn_b < 12) begin
      if (bitn_b == 0) cur_b = (fq_b.size() > 0) ? fq_b.pop_front() : 12'h123;
      adc_data_b = cur_b[11 - bitn_b];
      bitn_b++;
    end
  end

  // Scoreboard: every write pops an expected sample; write/done must land 2 cycles after frame end
  logic [7:0] exp_q[$];
  int   since = 0, wr_cnt = 0, done_cnt = 0, busy_drop = 0;
  logic conv_d = 1'b1, watch_busy = 1'b0;
  always @(negedge osc_clk) begin
    if (adc_conv && !conv_d) since = 0;
    else since++;
    conv_d = adc_conv;
    if (watch_busy && !busy) busy_drop++;
    if (wr_en) begin
      wr_cnt++;
      check("wr_latency", since, 2);
      check("write_was_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("wr_data", wr_data, exp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      check("done_align", since, 2);
    end
  end

  task automatic wait_conv(input logic rise, input int n);
    int   k = 0;
    int   cyc = 0;
    logic p = adc_conv;
    while (k < n && cyc < 3000) begin
      @(negedge osc_clk);
      if (rise ? (adc_conv && !p) : (!adc_conv && p)) k++;
      p = adc_conv;
      cyc++;
    end
    if (k < n) check("conv_edge_timeout", k, n);
  endtask

  task automatic begin_capture(input logic [1:0] mode, input logic cont,
                               input logic [7:0] lvl, input logic [15:0] len);
    wait_conv(1'b0, 1);
    fq = stage;
    stage.delete();
    trig_mode   = mode;
    continuous  = cont;
    trig_level  = lvl;
    capture_len = len;
    start = 1'b1;
    @(negedge osc_clk);
    start = 1'b0;
  endtask

  initial begin
    int          d0, w0, rises, cyc;
    logic        pc, seen;
    logic [11:0] got;
    adc_data = 1'b0; adc_data_b = 1'b0; start = 1'b0; start_b = 1'b0; abort = 1'b0;
    trig_mode = 2'd0; continuous = 1'b0; trig_level = 8'h00; capture_len = 16'd1;
    sink_full = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge osc_clk);
    check("rst_adc_clk", adc_clk, 0);
    check("rst_adc_conv", adc_conv, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_armed", armed, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Single frame 0x6D4F, auto, one sample
    stage.push_back(16'h6D4F);
    exp_q.push_back(8'hB5);
    d0 = done_cnt; w0 = wr_cnt;
    begin_capture(2'd0, 1'b0, 8'h00, 16'd1);
    check("t1_armed", armed, 1);
    wait_conv(1'b1, 1);
    repeat (4) @(negedge osc_clk);
    check("t1_writes", wr_cnt - w0, 1);
    check("t1_done", done_cnt - d0, 1);
    check("t1_wr_data_held", wr_data, 8'hB5);
    check("t1_idle", busy, 0);

    // Rising trigger at 0x80, two samples
    foreach (stage[i]) stage.delete(i);
    stage.push_back(mk(8'h10)); stage.push_back(mk(8'h70)); stage.push_back(mk(8'h90));
    stage.push_back(mk(8'hA0)); stage.push_back(mk(8'h20));
    exp_q.push_back(8'h90); exp_q.push_back(8'hA0);
    d0 = done_cnt; w0 = wr_cnt;
    begin_capture(2'd1, 1'b0, 8'h80, 16'd2);
    wait_conv(1'b1, 5);
    repeat (4) @(negedge osc_clk);
    check("t2_writes", wr_cnt - w0, 2);
    check("t2_done", done_cnt - d0, 1);
    check("t2_idle", busy, 0);

    // Falling trigger, continuous, one sample per capture (0x80 itself triggers)
    stage.push_back(mk(8'h90)); stage.push_back(mk(8'h80));
    stage.push_back(mk(8'hA0)); stage.push_back(mk(8'h70));
    exp_q.push_back(8'h80); exp_q.push_back(8'h70);
    d0 = done_cnt; w0 = wr_cnt;
    begin_capture(2'd2, 1'b1, 8'h80, 16'd1);
    watch_busy = 1'b1; busy_drop = 0;
    wait_conv(1'b1, 4);
    repeat (4) @(negedge osc_clk);
    watch_busy = 1'b0;
    check("t3_writes", wr_cnt - w0, 2);
    check("t3_done", done_cnt - d0, 2);
    check("t3_busy_held", busy_drop, 0);
    check("t3_rearmed", armed, 1);
    abort = 1'b1;
    @(negedge osc_clk);
    abort = 1'b0;
    check("t3_abort_idle", busy, 0);

    // Overrun: sink full during the 2nd of 4 samples
    stage.push_back(mk(8'h11)); stage.push_back(mk(8'h22));
    stage.push_back(mk(8'h33)); stage.push_back(mk(8'h44));
    exp_q.push_back(8'h11); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    d0 = done_cnt; w0 = wr_cnt;
    begin_capture(2'd0, 1'b0, 8'h00, 16'd4);
    wait_conv(1'b1, 1);
    repeat (4) @(negedge osc_clk);
    sink_full = 1'b1;
    wait_conv(1'b1, 1);
    repeat (4) @(negedge osc_clk);
    sink_full = 1'b0;
    check("t4_overrun_set", overrun, 1);
    check("t4_no_done_yet", done_cnt - d0, 0);
    wait_conv(1'b1, 2);
    repeat (4) @(negedge osc_clk);
    check("t4_writes", wr_cnt - w0, 3);
    check("t4_done", done_cnt - d0, 1);
    check("t4_overrun_sticky", overrun, 1);

    // Abort mid-capture; the arming start also clears overrun
    stage.push_back(mk(8'h5A)); stage.push_back(mk(8'h6B));
    stage.push_back(mk(8'h7C)); stage.push_back(mk(8'h0D));
    exp_q.push_back(8'h5A); exp_q.push_back(8'h6B);
    d0 = done_cnt; w0 = wr_cnt;
    begin_capture(2'd0, 1'b0, 8'h00, 16'd4);
    check("t5_overrun_cleared", overrun, 0);
    wait_conv(1'b1, 2);
    repeat (4) @(negedge osc_clk);
    abort = 1'b1;
    @(negedge osc_clk);
    abort = 1'b0;
    check("t5_abort_idle", busy, 0);
    wait_conv(1'b1, 2);
    repeat (4) @(negedge osc_clk);
    check("t5_writes", wr_cnt - w0, 2);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_scoreboard_empty", exp_q.size(), 0);

    // Asynchronous reset mid-frame while armed
    begin_capture(2'd1, 1'b0, 8'hFF, 16'd1);
    check("t6_armed", armed, 1);
    repeat (10) @(negedge osc_clk);
    #2 reset = 1'b1;
    #1;
    check("t6_adc_clk", adc_clk, 0);
    check("t6_adc_conv", adc_conv, 1);
    check("t6_wr_en", wr_en, 0);
    check("t6_wr_data", wr_data, 0);
    check("t6_armed", armed, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_overrun", overrun, 0);
    @(negedge osc_clk);
    reset = 1'b0;
    rises = 0; pc = adc_clk; cyc = 0;
    while (cyc < 200) begin
      @(negedge osc_clk);
      if (adc_clk && !pc) rises++;
      pc = adc_clk;
      cyc++;
      if (!adc_conv) break;
    end
    check("t6_conv_periods", rises, 3);

    // 12-bit frame, no pad, full-width sample
    cyc = 0; pc = adc_conv_b;
    while (cyc < 400 && !(!adc_conv_b && pc)) begin
      pc = adc_conv_b;
      @(negedge osc_clk);
      cyc++;
    end
    fq_b.push_back(12'hABC);
    start_b = 1'b1;
    @(negedge osc_clk);
    start_b = 1'b0;
    seen = 1'b0; got = '0; cyc = 0;
    while (cyc < 400 && !seen) begin
      @(negedge osc_clk);
      if (wr_en_b) begin
        seen = 1'b1;
        got  = wr_data_b;
      end
      cyc++;
    end
    check("t7_write_seen", seen, 1);
    check("t7_wr_data", got, 12'hABC);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
